// File: rtl/arb_resp_router.sv
// arb_resp_router: passes the arbiter's winning request straight to a single
// slave, remembers which master won each granted request in a small index
// FIFO, and routes the slave's in-order responses back to that master.
module arb_resp_router #(
    parameter int NumIn    = 4,
    parameter int ReqWidth = 32,
    parameter int RspWidth = 32,
    parameter int MaxTrans = 4,
    localparam int IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1,
    localparam int CntWidth = $clog2(MaxTrans + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    // request side (arbiter root -> slave)
    input  logic                arb_req_i,
    output logic                arb_gnt_o,
    input  logic [ReqWidth-1:0] arb_data_i,
    input  logic [IdxWidth-1:0] arb_idx_i,
    output logic                slv_req_o,
    input  logic                slv_gnt_i,
    output logic [ReqWidth-1:0] slv_data_o,
    // response side (slave -> masters)
    input  logic                slv_rsp_valid_i,
    output logic                slv_rsp_ready_o,
    input  logic [RspWidth-1:0] slv_rsp_data_i,
    output logic [NumIn-1:0]    mst_rsp_valid_o,
    input  logic [NumIn-1:0]    mst_rsp_ready_i,
    output logic [RspWidth-1:0] mst_rsp_data_o,
    // tracker status
    output logic [CntWidth-1:0] outstanding_o,
    output logic                full_o,
    output logic                empty_o
);

    localparam int PtrWidth = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

    logic [IdxWidth-1:0] idx_mem [MaxTrans];
    logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0] count_q;

    logic                push, pop;
    logic [IdxWidth-1:0] head_idx;
    logic                head_legal;

    function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] p);
        if (p == PtrWidth'(MaxTrans - 1)) return '0;
        return p + PtrWidth'(1);
    endfunction

    // Status flags come from the count register only, so the request side
    // never sees a combinational path from the response side.
    assign full_o        = (count_q == CntWidth'(MaxTrans));
    assign empty_o       = (count_q == '0);
    assign outstanding_o = count_q;

    // Zero-latency request path, gated only by the registered full flag.
    assign slv_req_o  = arb_req_i & ~full_o;
    assign arb_gnt_o  = slv_gnt_i & ~full_o;
    assign slv_data_o = arb_data_i;
    assign push       = arb_req_i & arb_gnt_o;

    // Response routing from the FIFO head; an out-of-range index routes nowhere.
    assign head_idx       = idx_mem[rd_ptr_q];
    assign head_legal     = ({1'b0, head_idx} < (IdxWidth + 1)'(NumIn));
    assign mst_rsp_data_o = slv_rsp_data_i;
    assign pop            = slv_rsp_valid_i & slv_rsp_ready_o;

    // Decode the head index into per-master valid and pick that master's ready.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        mst_rsp_valid_o = '0;
        slv_rsp_ready_o = 1'b0;
        if (!empty_o && head_legal) begin
            slv_rsp_ready_o = mst_rsp_ready_i[head_idx];
            for (int i = 0; i < NumIn; i++) begin
                mst_rsp_valid_o[i] = slv_rsp_valid_i & (head_idx == IdxWidth'(i));
            end
        end
    end

    // Index storage written on push.
    // NOTE: storage has no reset; the count and pointers alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) idx_mem[wr_ptr_q] <= arb_idx_i;
    end

    // Pointers and count; flush outranks any push or pop in the same cycle.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
            if (push && !pop)      count_q <= count_q + CntWidth'(1);
            else if (pop && !push) count_q <= count_q - CntWidth'(1);
        end
    end

    // Protocol checks, active only out of reset.
    a_rsp_when_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
        slv_rsp_valid_i |-> !empty_o)
        else $error("slave response valid while tracker empty");

    a_valid_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(mst_rsp_valid_o))
        else $error("mst_rsp_valid_o not one-hot");

    a_rsp_held : assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
        (slv_rsp_valid_i && !slv_rsp_ready_o) |=> slv_rsp_valid_i)
        else $error("slave response valid dropped before handshake");

    a_idx_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
        push |-> ({1'b0, arb_idx_i} < (IdxWidth + 1)'(NumIn)))
        else $error("upstream index out of range");

endmodule

// File: tb/tb_arb_resp_router.sv
// Self-checking bench for arb_resp_router (NumIn=4, MaxTrans=2): a queue-based
// model is compared on every falling edge, plus directed literal checks.
module tb_arb_resp_router;

    localparam int NumIn    = 4;
    localparam int ReqWidth = 32;
    localparam int RspWidth = 32;
    localparam int MaxTrans = 2;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                flush_i;
    logic                arb_req_i;
    logic                arb_gnt_o;
    logic [ReqWidth-1:0] arb_data_i;
    logic [1:0]          arb_idx_i;
    logic                slv_req_o;
    logic                slv_gnt_i;
    logic [ReqWidth-1:0] slv_data_o;
    logic                slv_rsp_valid_i;
    logic                slv_rsp_ready_o;
    logic [RspWidth-1:0] slv_rsp_data_i;
    logic [NumIn-1:0]    mst_rsp_valid_o;
    logic [NumIn-1:0]    mst_rsp_ready_i;
    logic [RspWidth-1:0] mst_rsp_data_o;
    logic [1:0]          outstanding_o;
    logic                full_o;
    logic                empty_o;

    int total = 0;
    int bad   = 0;

    arb_resp_router #(
        .NumIn(NumIn), .ReqWidth(ReqWidth), .RspWidth(RspWidth), .MaxTrans(MaxTrans)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .arb_req_i(arb_req_i), .arb_gnt_o(arb_gnt_o), .arb_data_i(arb_data_i),
        .arb_idx_i(arb_idx_i), .slv_req_o(slv_req_o), .slv_gnt_i(slv_gnt_i),
        .slv_data_o(slv_data_o), .slv_rsp_valid_i(slv_rsp_valid_i),
        .slv_rsp_ready_o(slv_rsp_ready_o), .slv_rsp_data_i(slv_rsp_data_i),
        .mst_rsp_valid_o(mst_rsp_valid_o), .mst_rsp_ready_i(mst_rsp_ready_i),
        .mst_rsp_data_o(mst_rsp_data_o), .outstanding_o(outstanding_o),
        .full_o(full_o), .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an ordered list of master indices awaiting a response.
    int q[$];

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q.delete();
        end else if (flush_i) begin
            q.delete();
        end else begin
            automatic bit do_push = arb_req_i && slv_gnt_i && (q.size() < MaxTrans);
            automatic bit do_pop  = slv_rsp_valid_i && (q.size() > 0) && mst_rsp_ready_i[q[0]];
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(int'(arb_idx_i));
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk_i) begin
        automatic int  n        = q.size();
        automatic bit  is_full  = (n == MaxTrans);
        automatic logic [3:0] exp_valid = '0;
        automatic bit  exp_ready = 1'b0;
        if (n > 0) begin
            exp_ready = mst_rsp_ready_i[q[0]];
            if (slv_rsp_valid_i) exp_valid[q[0]] = 1'b1;
        end
        check("m_outstanding", outstanding_o, n);
        check("m_full",        full_o, is_full);
        check("m_empty",       empty_o, n == 0);
        check("m_slv_req",     slv_req_o, arb_req_i && !is_full);
        check("m_arb_gnt",     arb_gnt_o, slv_gnt_i && !is_full);
        check("m_slv_data",    slv_data_o, arb_data_i);
        check("m_rsp_valid",   mst_rsp_valid_o, exp_valid);
        check("m_rsp_ready",   slv_rsp_ready_o, exp_ready);
        check("m_rsp_data",    mst_rsp_data_o, slv_rsp_data_i);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        arb_req_i       = 1'b0;
        slv_gnt_i       = 1'b0;
        slv_rsp_valid_i = 1'b0;
        mst_rsp_ready_i = 4'b1111;
    endtask

    task automatic push_one(input logic [1:0] idx);
        arb_req_i  = 1'b1;
        slv_gnt_i  = 1'b1;
        arb_idx_i  = idx;
        arb_data_i = 32'hA000_0000 | 32'(idx);
        tick();
        arb_req_i  = 1'b0;
    endtask

    initial begin
        rst_ni          = 1'b0;
        flush_i         = 1'b0;
        arb_data_i      = 32'h1234_5678;
        arb_idx_i       = 2'd0;
        slv_rsp_data_i  = 32'hDEAD_BEEF;
        idle_inputs();

        // Reset values
        #3;
        check("rst_outstanding", outstanding_o, 0);
        check("rst_empty",       empty_o, 1);
        check("rst_full",        full_o, 0);
        check("rst_valid",       mst_rsp_valid_o, 4'b0000);
        check("rst_ready",       slv_rsp_ready_o, 0);
        #9 rst_ni = 1'b1;
        tick();

        // Single transaction to master 2
        arb_req_i = 1'b1; slv_gnt_i = 1'b1; arb_idx_i = 2'd2;
        #1 check("t38_gnt", arb_gnt_o, 1);
        tick();
        arb_req_i = 1'b0;
        check("t38_cnt1", outstanding_o, 1);
        slv_rsp_valid_i = 1'b1; mst_rsp_ready_i = 4'b0100; slv_rsp_data_i = 32'h0000_0222;
        #1 check("t38_valid", mst_rsp_valid_o, 4'b0100);
        check("t38_ready", slv_rsp_ready_o, 1);
        tick();
        slv_rsp_valid_i = 1'b0;
        check("t38_cnt0", outstanding_o, 0);
        check("t38_empty", empty_o, 1);

        // Fill with 1 then 3, grant blocked, in-order routing
        mst_rsp_ready_i = 4'b1111;
        push_one(2'd1);
        push_one(2'd3);
        check("t39_full", full_o, 1);
        arb_req_i = 1'b1; slv_gnt_i = 1'b1; arb_idx_i = 2'd0;
        #1 check("t39_gnt_blocked", arb_gnt_o, 0);
        check("t39_req_blocked", slv_req_o, 0);
        arb_req_i = 1'b0;
        slv_rsp_valid_i = 1'b1;
        #1 check("t39_first", mst_rsp_valid_o, 4'b0010);
        tick();
        check("t39_second", mst_rsp_valid_o, 4'b1000);
        check("t39_cnt1", outstanding_o, 1);
        tick();
        slv_rsp_valid_i = 1'b0;
        check("t39_drained", outstanding_o, 0);

        // Full with simultaneous push attempt and pop
        push_one(2'd0);
        push_one(2'd1);
        arb_req_i = 1'b1; slv_gnt_i = 1'b1; arb_idx_i = 2'd2; slv_rsp_valid_i = 1'b1;
        #1 check("t40_gnt_blocked", arb_gnt_o, 0);
        check("t40_pop_head", mst_rsp_valid_o, 4'b0001);
        tick();
        slv_rsp_valid_i = 1'b0;
        check("t40_cnt1", outstanding_o, 1);
        check("t40_gnt_open", arb_gnt_o, 1);
        tick();
        arb_req_i = 1'b0;
        check("t40_cnt2", outstanding_o, 2);
        slv_rsp_valid_i = 1'b1;
        #1 check("t40_route1", mst_rsp_valid_o, 4'b0010);
        tick();
        check("t40_route2", mst_rsp_valid_o, 4'b0100);
        tick();
        slv_rsp_valid_i = 1'b0;
        check("t40_drained", outstanding_o, 0);

        // Steady push+pop at count 1, wrapping the pointers several times
        push_one(2'd0);
        for (int i = 0; i < 6; i++) begin
            logic [3:0] exp_oh;
            exp_oh = 4'b0001 << (i % 4);
            arb_req_i = 1'b1; slv_gnt_i = 1'b1; arb_idx_i = 2'((i + 1) % 4);
            slv_rsp_valid_i = 1'b1;
            #1 check("t41_route", mst_rsp_valid_o, exp_oh);
            tick();
            check("t41_cnt", outstanding_o, 1);
        end
        arb_req_i = 1'b0;
        #1 check("t41_last", mst_rsp_valid_o, 4'b0100);
        tick();
        slv_rsp_valid_i = 1'b0;
        check("t41_drained", outstanding_o, 0);

        // Master 0 back-pressures for three cycles
        push_one(2'd0);
        slv_rsp_valid_i = 1'b1; mst_rsp_ready_i = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            #1 check("t42_ready_low", slv_rsp_ready_o, 0);
            check("t42_valid_held", mst_rsp_valid_o, 4'b0001);
            tick();
            check("t42_no_pop", outstanding_o, 1);
        end
        mst_rsp_ready_i = 4'b1111;
        #1 check("t42_ready_high", slv_rsp_ready_o, 1);
        tick();
        slv_rsp_valid_i = 1'b0;
        check("t42_drained", outstanding_o, 0);

        // Flush with two entries, then async reset mid-stream
        push_one(2'd3);
        push_one(2'd2);
        check("t43_cnt2", outstanding_o, 2);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("t43_flush_cnt", outstanding_o, 0);
        check("t43_flush_empty", empty_o, 1);
        push_one(2'd1);
        check("t43_cnt1", outstanding_o, 1);
        mst_rsp_ready_i = 4'b0010;
        #1 check("t43_pre_rst_ready", slv_rsp_ready_o, 1);
        #1 rst_ni = 1'b0;
        #1 check("t43_rst_outstanding", outstanding_o, 0);
        check("t43_rst_empty", empty_o, 1);
        check("t43_rst_full", full_o, 0);
        check("t43_rst_valid", mst_rsp_valid_o, 4'b0000);
        check("t43_rst_ready", slv_rsp_ready_o, 0);
        tick();
        #2 rst_ni = 1'b1;
        idle_inputs();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
